// File: rtl/shreg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : shreg_pkg                                              |
// | Description : Shared mode encodings, controller states and default   |
// |               width for the universal shift register slice.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package shreg_pkg;

    // Default data width of the controlled register
    localparam int SHREG_DEF_WIDTH = 8;

    // Register mode-select encodings
    localparam logic [1:0] SR_SHL = 2'b00;  // shift left, zero fill
    localparam logic [1:0] SR_SHR = 2'b01;  // shift right, zero fill
    localparam logic [1:0] SR_ROL = 2'b10;  // rotate left
    localparam logic [1:0] SR_ROR = 2'b11;  // rotate right

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage : shreg_pkg
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : univ_shift_reg                                         |
// | Description : Universal shift register. load=1 captures ip, load=0   |
// |               applies one shift/rotate selected by mode per clock.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module univ_shift_reg
    import shreg_pkg::*;
#(
    parameter int WIDTH = SHREG_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_a,
    input  logic             load,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] ip,
    output logic [WIDTH-1:0] op
);

    logic [WIDTH-1:0] r_data;

    // Parallel load or single-step shift/rotate per clock
    always_ff @(posedge clk) begin
        if (rst_a) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= ip;
        end else begin
            case (mode)
                SR_SHL:  r_data <= {r_data[WIDTH-2:0], 1'b0};
                SR_SHR:  r_data <= {1'b0, r_data[WIDTH-1:1]};
                SR_ROL:  r_data <= {r_data[WIDTH-2:0], r_data[WIDTH-1]};
                default: r_data <= {r_data[0], r_data[WIDTH-1:1]};
            endcase
        end
    end

    assign op = r_data;

endmodule : univ_shift_reg
`default_nettype wire

// File: rtl/shreg_op_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : shreg_op_ctrl                                          |
// | Description : Command sequencer for univ_shift_reg. Accepts one      |
// |               {data, mode, count} command, loads the register, runs  |
// |               count shift/rotate steps and holds the result on a     |
// |               valid/ready response channel.                          |
// | Options     : SHREG_OP_CTRL_OPCNT_EN adds ops_done[15:0], a count    |
// |               of completed response handshakes.                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module shreg_op_ctrl
    import shreg_pkg::*;
#(
    parameter int WIDTH = SHREG_DEF_WIDTH,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_a,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [1:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             sr_load,
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_ip,
    input  logic [WIDTH-1:0] sr_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data
`ifdef SHREG_OP_CTRL_OPCNT_EN
    ,
    output logic [15:0]      ops_done
`endif
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_mode;
    logic [1:0]       w_mode_nxt;

    // State, remaining-step count and captured mode registers
    always_ff @(posedge clk) begin
        if (rst_a) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mode  <= SR_SHL;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    // Next-state and output decode; the register reloads its own output
    // whenever it is not shifting so its contents stay put
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        sr_load     = 1'b1;
        sr_mode     = SR_SHL;
        sr_ip       = sr_op;
        rsp_data    = sr_op;

        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    sr_ip      = cmd_data;
                    w_mode_nxt = cmd_mode;
                    w_cnt_nxt  = cmd_count;
                    w_state_nxt = (cmd_count != '0) ? ST_SHIFT : ST_RESP;
                end
            end
            ST_SHIFT: begin
                sr_load   = 1'b0;
                sr_mode   = r_mode;
                w_cnt_nxt = r_cnt - C_CNT_ONE;
                // Last step in flight: leave after this edge
                if (r_cnt <= C_CNT_ONE) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef SHREG_OP_CTRL_OPCNT_EN
    logic [15:0] r_ops_done;

    // Completed response handshakes, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (rst_a) begin
            r_ops_done <= 16'd0;
        end else if (rsp_valid && rsp_ready) begin
            r_ops_done <= r_ops_done + 16'd1;
        end
    end

    assign ops_done = r_ops_done;
`endif

endmodule : shreg_op_ctrl
`default_nettype wire

// File: tb/tb_shreg_op_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_shreg_op_ctrl                                       |
// | Description : Self-checking bench for shreg_op_ctrl driving a        |
// |               univ_shift_reg; directed and random commands checked   |
// |               against an arithmetic reference model.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_shreg_op_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_a;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic [1:0]       cmd_mode;
    logic [CNT_W-1:0] cmd_count;
    logic             sr_load;
    logic [1:0]       sr_mode;
    logic [WIDTH-1:0] sr_ip;
    logic [WIDTH-1:0] sr_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
`ifdef SHREG_OP_CTRL_OPCNT_EN
    logic [15:0]      ops_done;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int model_ops = 0;

    always #5 clk = ~clk;

    shreg_op_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rst_a     (rst_a),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_mode  (cmd_mode),
        .cmd_count (cmd_count),
        .sr_load   (sr_load),
        .sr_mode   (sr_mode),
        .sr_ip     (sr_ip),
        .sr_op     (sr_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
`ifdef SHREG_OP_CTRL_OPCNT_EN
        ,
        .ops_done  (ops_done)
`endif
    );

    univ_shift_reg #(.WIDTH(WIDTH)) u_sr (
        .clk   (clk),
        .rst_a (rst_a),
        .load  (sr_load),
        .mode  (sr_mode),
        .ip    (sr_ip),
        .op    (sr_op)
    );

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result: apply the operation n times with plain arithmetic
    function automatic logic [WIDTH-1:0] ref_result(input logic [WIDTH-1:0] d,
                                                    input logic [1:0] m, input int n);
        int v = int'(d);
        for (int i = 0; i < n; i++) begin
            case (m)
                2'b00: v = (v * 2) % 256;
                2'b01: v = v / 2;
                2'b10: v = ((v * 2) % 256) + (v / 128);
                default: v = (v / 2) + ((v % 2) * 128);
            endcase
        end
        return WIDTH'(v);
    endfunction

    task automatic check_ops();
`ifdef SHREG_OP_CTRL_OPCNT_EN
        chk("ops_done", 32'(ops_done), 32'(model_ops % 65536));
`endif
    endtask

    // Wait for cmd_ready, present a command, then check accept
    task automatic issue(input logic [WIDTH-1:0] d, input logic [1:0] m,
                         input logic [CNT_W-1:0] n, output bit ok);
        int waited = 0;
        ok = 1'b1;
        while (!cmd_ready && waited < 50) begin
            step();
            waited++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
            ok = 1'b0;
            return;
        end
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_mode  = m;
        cmd_count = n;
        #1;
        chk("accept_sr_ip", 32'(sr_ip), 32'(d));
        chk("accept_sr_load", 32'(sr_load), 32'd1);
        step();
        // Post-accept inputs are noise that must be ignored
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_data  = WIDTH'($urandom);
        cmd_mode  = 2'($urandom);
        cmd_count = CNT_W'($urandom);
    endtask

    // Full command: latency, result, backpressure and handshake
    task automatic run_cmd(input logic [WIDTH-1:0] d, input logic [1:0] m,
                           input logic [CNT_W-1:0] n, input int hold);
        bit ok;
        logic [WIDTH-1:0] exp;
        exp = ref_result(d, m, int'(n));
        issue(d, m, n, ok);
        if (!ok) return;
        for (int c = 1; c <= int'(n) + 1; c++) begin
            chk("lat_rsp_valid", 32'(rsp_valid), 32'(c == int'(n) + 1));
            chk("lat_sr_load", 32'(sr_load), 32'(c == int'(n) + 1));
            chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
            if (c <= int'(n)) step();
        end
        chk("rsp_data", 32'(rsp_data), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            step();
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'(exp));
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        model_ops++;
        #1;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
        check_ops();
    endtask

    initial begin
        bit ok;
        rst_a     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_mode  = 2'b00;
        cmd_count = '0;
        rsp_ready = 1'b0;
        step();
        step();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_sr_load", 32'(sr_load), 32'd1);
        chk("rst_sr_mode", 32'(sr_mode), 32'd0);
        check_ops();
        rst_a = 1'b0;
        step();
        chk("idle_sr_ip_hold", 32'(sr_ip), 32'd0);

        // Directed cases
        run_cmd(8'hCC, 2'b10, 4'd2, 0);
        run_cmd(8'hA5, 2'b01, 4'd0, 0);
        run_cmd(8'h8C, 2'b01, 4'd3, 0);
        run_cmd(8'h5A, 2'b11, 4'd4, 5);
        run_cmd(8'h81, 2'b00, 4'd15, 1);

        // Reset during the second SHIFT cycle drops the command
        issue(8'h3C, 2'b10, 4'd5, ok);
        if (ok) begin
            step();
            rst_a = 1'b1;
            step();
            rst_a = 1'b0;
            cmd_valid = 1'b0;
            model_ops = 0;
            #1;
            chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
            chk("midrst_sr_load", 32'(sr_load), 32'd1);
            check_ops();
        end
        run_cmd(8'hF0, 2'b11, 4'd3, 2);

        // Random commands
        for (int i = 0; i < 30; i++) begin
            run_cmd(WIDTH'($urandom), 2'($urandom), CNT_W'($urandom),
                    int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_shreg_op_ctrl
`default_nettype wire

// File: doc/shreg_op_ctrl.md
Name: shreg_op_ctrl

Overview:
- Command sequencer for the 8-bit universal shift register (univ_shift_reg).
- Accepts one command {data, mode, count} over a valid/ready handshake and loads the data into the register.
- Drives the shift/rotate mode for exactly count clocks, then presents the register output as a response held until the response is accepted.
- Sits between a requester (CPU-side or test driver) and the shift-register datapath; sole owner of the register's load/ip/mode pins.

Parameters:
- WIDTH, 8, data width of the controlled register.
- CNT_W, 4, width of cmd_count; 0..2^CNT_W-1 operations per command.

Ports:
- clk  in  1  system clock, rising edge.
- rst_a  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_data  in  WIDTH  value to load.
- cmd_mode  in  2  operation: 00 shift left, 01 shift right (zero fill), 10 rotate left, 11 rotate right.
- cmd_count  in  CNT_W  number of operations after load.
- sr_load  out  1  to register load: 1 = load sr_ip, 0 = perform sr_mode.
- sr_mode  out  2  to register mode select.
- sr_ip  out  WIDTH  to register parallel input.
- sr_op  in  WIDTH  from register parallel output.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumed.
- rsp_data  out  WIDTH  result value.

Behaviour:
- Reset (synchronous rst_a=1 at a clk edge):
  - state=IDLE, cnt_q=0, mode_q=00.
  - Outputs after reset: cmd_ready=1, rsp_valid=0, sr_load=1, sr_mode=00, sr_ip=sr_op (hold), rsp_data=sr_op.
- FSM states IDLE, SHIFT, RESP; all outputs decoded combinationally from state and registers.
- IDLE:
  - cmd_ready=1, sr_load=1, sr_ip=sr_op (register holds).
  - On cmd_valid&&cmd_ready in the same cycle: sr_ip=cmd_data, so the register loads at that edge; capture mode_q=cmd_mode and cnt_q=cmd_count.
  - Next state is SHIFT if cmd_count!=0, else RESP.
- SHIFT:
  - cmd_ready=0, sr_load=0, sr_mode=mode_q; cnt_q decrements every clock.
  - When cnt_q==1, next state is RESP; exactly cmd_count operations are applied.
- RESP:
  - rsp_valid=1, rsp_data=sr_op, sr_load=1, sr_ip=sr_op, so data is held stable.
  - On rsp_valid&&rsp_ready, go to IDLE; cmd_ready rises the following cycle, giving no overlap of response and new command.
- Latency: rsp_valid asserts cmd_count+1 clocks after the accept edge (count 0 gives 1 clock).
- Throughput: one command per cmd_count+2 clocks minimum.
- cmd_valid while cmd_ready=0 is ignored; inputs need not be stable outside the accept cycle.
- rsp_data is stable for the whole time rsp_valid=1 (backpressure safe).
- Reset mid-operation (SHIFT or RESP): in-flight command dropped, next cycle is IDLE, rsp_valid=0; register contents are undefined to the requester.
- sr_mode outside SHIFT is 00 and is don't-care to the register because sr_load=1.

Optional Feature:
- Macro: SHREG_OP_CTRL_OPCNT_EN.
- Defined:
  - Adds output ops_done[15:0].
  - Counts completed response handshakes; wraps 0xFFFF to 0x0000; reset value 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package shreg_pkg holds:
  - mode encodings SR_SHL=2'b00, SR_SHR=2'b01, SR_ROL=2'b10, SR_ROR=2'b11;
  - state typedef/localparams ST_IDLE, ST_SHIFT, ST_RESP;
  - default WIDTH.
- No sub-module inside the controller.
- Bench and top level instantiate shreg_op_ctrl plus univ_shift_reg, sharing clk/rst_a.

Test Plan:
- Reset: rst_a=1 for 2 clocks -> cmd_ready=1, rsp_valid=0, sr_load=1; ops_done=0 if enabled.
- Rotate left: data=0xCC, mode=10, count=2 -> rsp_valid exactly 3 clocks after accept, rsp_data=0x33.
- Zero count: data=0xA5, count=0 -> rsp_valid 1 clock after accept, rsp_data=0xA5, sr_load never 0.
- Shift right: data=0x8C, mode=01, count=3 -> rsp_data=0x11.
- Backpressure: hold rsp_ready=0 for 5 clocks with cmd_valid=1 -> rsp_data stable, cmd_ready=0, no second accept; after handshake cmd_ready=1 next clock.
- Reset mid-shift: count=5, rst_a=1 on 2nd SHIFT clock -> next cycle IDLE, rsp_valid=0; new command then completes normally.
